// File: rtl/analyzer_pkg.sv
// Shared definitions for the logic-analyzer capture path (capture and readout FSMs).
package analyzer_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_FILL = 3'd1,
    ARMED    = 3'd2,
    POST     = 3'd3,
    DONE     = 3'd4
  } cap_state_e;

endpackage

// File: rtl/analyzer_capture_ctrl_if.sv
// Control, status and sample-RAM write-port signals of the capture controller.
interface analyzer_capture_ctrl_if
  import analyzer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);
  logic              start;
  logic              abort;
  logic              clear;
  logic              sample_valid;
  logic              trigger;
  logic [ADDR_W-1:0] pretrig_depth;
  logic [ADDR_W-1:0] posttrig_depth;
  logic              idle;
  logic              pre_trigger;
  logic              post_trigger;
  logic              done;
  logic              aborted;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              wrapped;

  modport master (
    output start, abort, clear, sample_valid, trigger, pretrig_depth, posttrig_depth,
    input  idle, pre_trigger, post_trigger, done, aborted,
    input  wr_en, wr_addr, trig_addr, start_addr, wrapped
  );

  modport slave (
    input  start, abort, clear, sample_valid, trigger, pretrig_depth, posttrig_depth,
    output idle, pre_trigger, post_trigger, done, aborted,
    output wr_en, wr_addr, trig_addr, start_addr, wrapped
  );
endinterface

// File: rtl/analyzer_wr_ptr.sv
// Wrapping sample-RAM write pointer with wrapped flag and a separately clearable sample counter.
module analyzer_wr_ptr #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              cnt_clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wrapped,
  output logic [CNT_W-1:0]  count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr <= '0;
      wrapped <= 1'b0;
      count   <= '0;
    end else if (clr) begin
      wr_addr <= '0;
      wrapped <= 1'b0;
      count   <= '0;
    end else begin
      if (inc) begin
        wr_addr <= wr_addr + 1'b1;
        if (wr_addr == '1) wrapped <= 1'b1;
      end
      // The trigger write itself is not part of the post-trigger count.
      if (cnt_clr)  count <= '0;
      else if (inc) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/analyzer_capture_ctrl.sv
// Capture sequencer for the circular sample RAM: pre-trigger fill, trigger qualification,
// post-trigger length and abort; reports trigger and oldest-sample addresses.
module analyzer_capture_ctrl
  import analyzer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  analyzer_capture_ctrl_if.slave  bus
);

  localparam int unsigned      DEPTH    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  pre_q, post_q;
  logic [CNT_W-1:0]  pre_in, post_in, depth_sum, post_clamp;
  logic [ADDR_W-1:0] trig_addr_q, start_addr_q;
  logic              aborted_q;

  logic              active, write, trig_hit, start_go, abort_go, cnt_clr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wrapped;
  logic [CNT_W-1:0]  count, count_inc;

  assign active    = (state_q == PRE_FILL) || (state_q == ARMED) || (state_q == POST);
  assign abort_go  = bus.abort & active;
  assign start_go  = bus.start & ~bus.abort & ((state_q == IDLE) || (state_q == DONE));
  assign write     = bus.sample_valid & active & ~bus.abort;
  assign trig_hit  = write & bus.trigger & (state_q == ARMED);
  assign count_inc = count + 1'b1;

  // Post length is clamped so the capture never overwrites its own oldest sample.
  assign pre_in     = CNT_W'(bus.pretrig_depth);
  assign post_in    = CNT_W'(bus.posttrig_depth);
  assign depth_sum  = pre_in + post_in;
  assign post_clamp = (depth_sum > DEPTH_M1) ? (DEPTH_M1 - pre_in) : post_in;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    if (abort_go) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_go) state_d = (pre_in == '0) ? ARMED : PRE_FILL;
        end
        DONE: begin
          if (start_go)       state_d = (pre_in == '0) ? ARMED : PRE_FILL;
          else if (bus.clear) state_d = IDLE;
        end
        PRE_FILL: begin
          if (write && (count_inc == pre_q)) state_d = ARMED;
        end
        ARMED: begin
          if (trig_hit) begin
            cnt_clr = 1'b1;
            state_d = (post_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (write && (count_inc == post_q)) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      post_q       <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        pre_q     <= pre_in;
        post_q    <= post_clamp;
        aborted_q <= 1'b0;
      end
      if (abort_go) aborted_q <= 1'b1;
      if (trig_hit) begin
        trig_addr_q  <= wr_addr;
        start_addr_q <= wr_addr - pre_q[ADDR_W-1:0];
      end
    end
  end

  analyzer_wr_ptr #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_wr_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start_go),
    .cnt_clr (cnt_clr),
    .inc     (write),
    .wr_addr (wr_addr),
    .wrapped (wrapped),
    .count   (count)
  );

  assign bus.idle         = (state_q == IDLE);
  assign bus.pre_trigger  = (state_q == PRE_FILL) || (state_q == ARMED);
  assign bus.post_trigger = (state_q == POST);
  assign bus.done         = (state_q == DONE);
  assign bus.aborted      = aborted_q;
  assign bus.wr_en        = write;
  assign bus.wr_addr      = wr_addr;
  assign bus.trig_addr    = trig_addr_q;
  assign bus.start_addr   = start_addr_q;
  assign bus.wrapped      = wrapped;

endmodule

// File: tb/tb_analyzer_capture_ctrl.sv
// Scoreboard bench for analyzer_capture_ctrl: sample-index reference model feeds expected
// write addresses to a queue that a negedge monitor drains against wr_en/wr_addr.
module tb_analyzer_capture_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int          DEPTH  = 1 << ADDR_W;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_q[$];

  analyzer_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  analyzer_capture_ctrl #(
    .ADDR_W (ADDR_W),
    .CNT_W  (ADDR_W + 1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: every RAM write must match the next expected address.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("wr_en_unexpected", bus.wr_en, 0);
      else check("wr_addr", bus.wr_addr, exp_q.pop_front());
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_idle"}, bus.idle, 1);
    check({tag, "_pre_trigger"}, bus.pre_trigger, 0);
    check({tag, "_post_trigger"}, bus.post_trigger, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_aborted"}, bus.aborted, 0);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_trig_addr"}, bus.trig_addr, 0);
    check({tag, "_start_addr"}, bus.start_addr, 0);
    check({tag, "_wrapped"}, bus.wrapped, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // vpat: 0 always valid, 1 toggling, 2 random. tmode: 0 random, 1 only at sample trig_n
  // (and on every invalid cycle), 2 held high.
  task automatic run_capture(input int pre, input int post, input int vpat, input int tmode,
                             input int trig_n, output int o_trig, output int o_start,
                             output int o_wrap, output int o_total);
    int post_eff, n, t;
    bit ended, v, tr;
    post_eff = (pre + post > DEPTH - 1) ? (DEPTH - 1 - pre) : post;
    bus.start          = 1'b1;
    bus.clear          = 1'($urandom_range(0, 1));
    bus.sample_valid   = 1'b1;
    bus.trigger        = 1'($urandom_range(0, 1));
    bus.pretrig_depth  = ADDR_W'(pre);
    bus.posttrig_depth = ADDR_W'(post);
    tick();
    bus.start = 1'b0;
    bus.clear = 1'b0;
    check("pre_trigger_after_start", bus.pre_trigger, 1);
    check("aborted_after_start", bus.aborted, 0);
    check("wr_addr_after_start", bus.wr_addr, 0);
    check("wrapped_after_start", bus.wrapped, 0);
    n = 0;
    t = -1;
    ended = 1'b0;
    for (int k = 0; k < 3000 && !ended; k++) begin
      case (vpat)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 9) < 6);
      endcase
      case (tmode)
        0:       tr = ($urandom_range(0, 6) == 0);
        1:       tr = v ? (n == trig_n) : 1'b1;
        default: tr = 1'b1;
      endcase
      bus.sample_valid   = v;
      bus.trigger        = tr;
      bus.start          = ($urandom_range(0, 7) == 0);
      bus.clear          = ($urandom_range(0, 7) == 0);
      bus.pretrig_depth  = ADDR_W'($urandom);
      bus.posttrig_depth = ADDR_W'($urandom);
      if (v) begin
        exp_q.push_back(n % DEPTH);
        if (t < 0 && n >= pre && tr) t = n;
        if (t >= 0 && n == t + post_eff) ended = 1'b1;
        n++;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.sample_valid = 1'b1;
    bus.trigger = 1'b1;
    tick();
    tick();
    check("done", bus.done, 1);
    check("post_trigger_in_done", bus.post_trigger, 0);
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
    check("trig_addr", bus.trig_addr, ((t % DEPTH) + DEPTH) % DEPTH);
    check("start_addr", bus.start_addr, (((t - pre) % DEPTH) + DEPTH) % DEPTH);
    check("wrapped", bus.wrapped, (n >= DEPTH) ? 1 : 0);
    check("wr_addr_final", bus.wr_addr, n % DEPTH);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_in_done_done", bus.done, 1);
    check("abort_in_done_aborted", bus.aborted, 0);
    if ($urandom_range(0, 1) == 1) begin
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("clear_to_idle", bus.idle, 1);
    end
    bus.sample_valid = 1'b0;
    bus.trigger = 1'b0;
    o_trig  = t % DEPTH;
    o_start = (((t - pre) % DEPTH) + DEPTH) % DEPTH;
    o_wrap  = (n >= DEPTH) ? 1 : 0;
    o_total = n;
  endtask

  initial begin
    int tg, st, wr, tot;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.clear = 1'b0;
    bus.sample_valid = 1'b0;
    bus.trigger = 1'b0;
    bus.pretrig_depth = '0;
    bus.posttrig_depth = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 check_reset_state("por");
    @(negedge clock) reset_n = 1'b1;
    tick();
    check("idle_after_release", bus.idle, 1);

    run_capture(3, 4, 0, 1, 5, tg, st, wr, tot);
    check("t1_trig_addr", tg, 5);
    check("t1_start_addr", st, 2);
    check("t1_wrapped", wr, 0);
    check("t1_total", tot, 10);

    run_capture(3, 4, 0, 2, 0, tg, st, wr, tot);
    check("t2_trig_addr", tg, 3);
    check("t2_start_addr", st, 0);

    run_capture(4, 8, 0, 1, 19, tg, st, wr, tot);
    check("t3_trig_addr", tg, 3);
    check("t3_start_addr", st, 15);
    check("t3_wrapped", wr, 1);
    check("t3_last_addr", (tot - 1) % DEPTH, 11);

    run_capture(10, 10, 0, 1, 10, tg, st, wr, tot);
    check("t4_post_len", tot - tg - 1, 5);

    run_capture(2, 3, 1, 1, 5, tg, st, wr, tot);
    check("t6_trig_addr", tg, 5);

    run_capture(0, 0, 2, 0, 0, tg, st, wr, tot);

    // Abort coinciding with a qualified trigger in ARMED.
    bus.start = 1'b1;
    bus.pretrig_depth = ADDR_W'(2);
    bus.posttrig_depth = ADDR_W'(5);
    tick();
    bus.start = 1'b0;
    bus.sample_valid = 1'b1;
    exp_q.push_back(0);
    tick();
    exp_q.push_back(1);
    tick();
    check("abort_armed_pre_trigger", bus.pre_trigger, 1);
    bus.trigger = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.trigger = 1'b0;
    bus.sample_valid = 1'b0;
    check("abort_idle", bus.idle, 1);
    check("abort_aborted", bus.aborted, 1);
    check("abort_pending", exp_q.size(), 0);
    check("abort_wr_addr", bus.wr_addr, 2);
    exp_q.delete();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_in_idle_sticky", bus.aborted, 1);
    run_capture(1, 2, 0, 0, 0, tg, st, wr, tot);

    // Asynchronous reset in the middle of POST.
    bus.start = 1'b1;
    bus.pretrig_depth = '0;
    bus.posttrig_depth = ADDR_W'(8);
    tick();
    bus.start = 1'b0;
    bus.sample_valid = 1'b1;
    bus.trigger = 1'b1;
    exp_q.push_back(0);
    tick();
    bus.trigger = 1'b0;
    exp_q.push_back(1);
    tick();
    exp_q.push_back(2);
    tick();
    bus.sample_valid = 1'b0;
    check("mid_post_state", bus.post_trigger, 1);
    check("mid_post_trig_addr", bus.trig_addr, 0);
    #2 reset_n = 1'b0;
    #1 check_reset_state("async_reset");
    exp_q.delete();
    @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    check("idle_after_mid_reset", bus.idle, 1);

    for (int i = 0; i < 20; i++)
      run_capture($urandom_range(0, 15), $urandom_range(0, 15), 2, 0, 0, tg, st, wr, tot);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
